// File: rtl/hslp_mul_pipe.sv
// rtl/hslp_mul_pipe.sv - pipelined nibble-tile truncated approximate multiplier (optional HSLP_COMP_EN bias + saturation)
module hslp_mul_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int KW    = $clog2(2*WIDTH)+1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [KW-1:0]        k,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int N  = WIDTH/4;
    localparam int NT = N*N;
    localparam int PW = 2*WIDTH;
`ifdef HSLP_COMP_EN
    localparam int AW = PW+1;
`else
    localparam int AW = PW;
`endif
    localparam logic [KW-1:0] KMAX = KW'(PW);

    logic                  advance;
    logic                  v0, v1, v2;
    logic [WIDTH-1:0]      a0, b0;
    logic [KW-1:0]         keff0;
    logic [TAG_W-1:0]      tag0, tag1;
    logic [NT-1:0][7:0]    tile_next, tile1;
    logic [KW-1:0]         k_eff_in;
    logic [AW-1:0]         acc;
    logic [PW-1:0]         result;
`ifdef HSLP_COMP_EN
    logic [KW-1:0]         keff1;
    logic [AW-1:0]         bias, total;
`endif

    assign advance   = !v2 || out_ready;
    assign in_ready  = advance;
    assign out_valid = v2;
    assign busy      = v0 | v1 | v2;
    assign k_eff_in  = (k > KMAX) ? KMAX : k;

    // Tile products with every bit below the truncation column cleared.
    always_comb begin
        logic [7:0] pp;
        pp        = '0;
        tile_next = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                pp = {4'b0, a0[4*i +: 4]} * {4'b0, b0[4*j +: 4]};
                for (int t = 0; t < 8; t++) begin
                    if (KW'(4*(i+j)+t) >= keff0)
                        tile_next[i*N+j][t] = pp[t];
                end
            end
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = acc + (AW'(tile1[i*N+j]) << (4*(i+j)));
            end
        end
    end

`ifdef HSLP_COMP_EN
    // Half-LSB bias at the truncation column; extra acc bit catches overflow.
    always_comb begin
        bias   = (keff1 == '0) ? '0 : (AW'(1) << (keff1 - KW'(1)));
        total  = acc + bias;
        result = total[PW] ? '1 : total[PW-1:0];
    end
`else
    assign result = acc;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            a0      <= '0;
            b0      <= '0;
            keff0   <= '0;
            tag0    <= '0;
            tile1   <= '0;
            tag1    <= '0;
            prod    <= '0;
            out_tag <= '0;
`ifdef HSLP_COMP_EN
            keff1   <= '0;
`endif
        end else if (advance) begin
            v0 <= in_valid;
            v1 <= v0;
            v2 <= v1;
            if (in_valid) begin
                a0    <= a;
                b0    <= b;
                keff0 <= k_eff_in;
                tag0  <= in_tag;
            end
            if (v0) begin
                tile1 <= tile_next;
                tag1  <= tag0;
`ifdef HSLP_COMP_EN
                keff1 <= keff0;
`endif
            end
            if (v1) begin
                prod    <= result;
                out_tag <= tag1;
            end
        end
    end

endmodule

// File: tb/tb_hslp_mul_pipe.sv
// tb/tb_hslp_mul_pipe.sv - scoreboard bench driving WIDTH=8 and WIDTH=16 instances in lockstep
module tb_hslp_mul_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, in_valid, out_ready;
    logic [7:0]  a8, b8;
    logic [4:0]  k8;
    logic [15:0] a16, b16;
    logic [5:0]  k16;
    logic [3:0]  in_tag;
    logic        in_ready8, in_ready16, out_valid8, out_valid16, busy8, busy16;
    logic [15:0] prod8;
    logic [31:0] prod16;
    logic [3:0]  tag8, tag16;

    hslp_mul_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
        .a(a8), .b(b8), .k(k8), .in_tag(in_tag),
        .out_valid(out_valid8), .out_ready(out_ready), .prod(prod8),
        .out_tag(tag8), .busy(busy8)
    );

    hslp_mul_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
        .a(a16), .b(b16), .k(k16), .in_tag(in_tag),
        .out_valid(out_valid16), .out_ready(out_ready), .prod(prod16),
        .out_tag(tag16), .busy(busy16)
    );

`ifdef HSLP_COMP_EN
    localparam longint E8_K8   = 64896;
    localparam longint E16_K4  = 65528;
    localparam longint E8_K20  = 32768;
    localparam longint E16_K40 = 64'd2147483648;
`else
    localparam longint E8_K8   = 64768;
    localparam longint E16_K4  = 65520;
    localparam longint E8_K20  = 0;
    localparam longint E16_K40 = 0;
`endif

    typedef struct {
        longint     e8;
        longint     e16;
        logic [3:0] tag;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    bit         rand_mode = 1'b0;
    logic [3:0] tag_ctr = 4'd0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sum of each 4x4 tile product's bits that land at or above the truncation column.
    function automatic longint model(input int w, input longint a, input longint b, input int k);
        int     keff;
        int     col;
        longint pp;
        longint sum;
        longint lim;
        keff = (k > 2*w) ? 2*w : k;
        sum  = 0;
        lim  = (longint'(1) << (2*w)) - 1;
        for (int i = 0; i < w/4; i++) begin
            for (int j = 0; j < w/4; j++) begin
                pp = ((a >> (4*i)) & 15) * ((b >> (4*j)) & 15);
                for (int t = 0; t < 8; t++) begin
                    col = 4*(i+j) + t;
                    if (col >= keff)
                        sum += ((pp >> t) & 1) << col;
                end
            end
        end
`ifdef HSLP_COMP_EN
        if (keff >= 1)
            sum += longint'(1) << (keff-1);
        if (sum > lim)
            sum = lim;
`else
        sum &= lim;
`endif
        return sum;
    endfunction

    task automatic step();
        in_valid  = 1'b0;
        out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] ia8, input logic [7:0] ib8, input logic [4:0] ik8,
                        input logic [15:0] ia16, input logic [15:0] ib16, input logic [5:0] ik16,
                        input longint e8, input longint e16);
        bit   done;
        int   guard;
        exp_t e;
        done  = 1'b0;
        guard = 0;
        in_valid = 1'b1;
        a8 = ia8; b8 = ib8; k8 = ik8;
        a16 = ia16; b16 = ib16; k16 = ik16;
        in_tag = tag_ctr;
        while (!done && guard < 200) begin
            out_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_ready8) begin
                e.e8  = e8;
                e.e16 = e16;
                e.tag = tag_ctr;
                sb.push_back(e);
                tag_ctr = tag_ctr + 4'd1;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        if (!done)
            chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [5:0] kk16);
        logic [7:0]  x8, y8;
        logic [4:0]  kk8;
        logic [15:0] x16, y16;
        x8  = 8'($urandom);
        y8  = 8'($urandom);
        kk8 = 5'($urandom_range(0, 31));
        x16 = 16'($urandom);
        y16 = 16'($urandom);
        send(x8, y8, kk8, x16, y16, kk16,
             model(8, longint'(x8), longint'(y8), int'(kk8)),
             model(16, longint'(x16), longint'(y16), int'(kk16)));
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 300) begin
            step();
            g++;
        end
        if (sb.size() != 0)
            chk("drain_timeout", longint'(sb.size()), 0);
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall behaviour.
    initial begin
        exp_t        e;
        bit          held;
        logic [15:0] held_p8;
        logic [31:0] held_p16;
        logic [3:0]  held_tag;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 1'b0;
            end else begin
                chk("valid_match", longint'(out_valid16), longint'(out_valid8));
                chk("ready_match", longint'(in_ready16), longint'(in_ready8));
                if (held && out_valid8) begin
                    chk("hold_prod8", longint'(prod8), longint'(held_p8));
                    chk("hold_prod16", longint'(prod16), longint'(held_p16));
                    chk("hold_tag", longint'(tag8), longint'(held_tag));
                end
                held = 1'b0;
                if (out_valid8 && !out_ready) begin
                    chk("in_ready_stall", longint'(in_ready8), 0);
                    held     = 1'b1;
                    held_p8  = prod8;
                    held_p16 = prod16;
                    held_tag = tag8;
                end
                if (out_valid8 && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("prod8", longint'(prod8), e.e8);
                        chk("prod16", longint'(prod16), e.e16);
                        chk("tag8", longint'(tag8), longint'(e.tag));
                        chk("tag16", longint'(tag16), longint'(e.tag));
                    end
                end
            end
        end
    end

    initial begin
        int lat;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a8 = '0; b8 = '0; k8 = '0; a16 = '0; b16 = '0; k16 = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid8), 0);
        chk("rst_busy", longint'(busy8), 0);
        chk("rst_prod", longint'(prod8), 0);
        chk("rst_tag", longint'(tag8), 0);
        chk("rst_in_ready", longint'(in_ready8), 1);
        chk("rst_prod16", longint'(prod16), 0);
        @(posedge clk);
        #1;

        send(8'd255, 8'd255, 5'd0, 16'hFFFF, 16'd1, 6'd4, 65025, E16_K4);
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            if (out_valid8) begin
                lat  = c;
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("latency", lat, 3);
        @(posedge clk);
        #1;

        send(8'd255, 8'd255, 5'd8, 16'hFFFF, 16'hFFFF, 6'd0, E8_K8, 64'd4294836225);
        send(8'd200, 8'd77, 5'd20, 16'd1234, 16'd5678, 6'd40, E8_K20, E16_K40);
        send(8'd200, 8'd77, 5'd0, 16'd1234, 16'd5678, 6'd0, 15400, 7006652);
        drain();

        rand_mode = 1'b1;
        repeat (20) begin
            send_rand(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 3) == 0)
                step();
        end
        for (int kk = 0; kk <= 32; kk++)
            send_rand(6'(kk));
        drain();
        rand_mode = 1'b0;

        send_rand(6'd3);
        send_rand(6'd9);
        send_rand(6'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_out_valid", longint'(out_valid8), 0);
        chk("midrst_busy8", longint'(busy8), 0);
        chk("midrst_busy16", longint'(busy16), 0);
        @(posedge clk);
        #1;
        repeat (8) step();

        send(8'd200, 8'd77, 5'd0, 16'd1234, 16'd5678, 6'd0, 15400, 7006652);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
